// File: rtl/vnu_f1_pkg.sv
// Shared derivations for the multi-lane VNU.f1 stage: address widths and the
// sign-fold that maps a (y0, y1) message pair onto a LUT page address.
package vnu_f1_pkg;

    localparam int MAX_Q      = 8;
    localparam int MAX_PAGE_W = 2 * MAX_Q - 1;

    typedef struct packed {
        logic                  fold;
        logic [MAX_PAGE_W-1:0] page;
    } fold_page_t;

    function automatic int frame_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int page_aw(input int q);
        return 2 * q - 1;
    endfunction

    // A negative y0 inverts both messages, so the LUT only stores the
    // non-negative half-plane and y0's sign bit drops out of the page.
    function automatic fold_page_t fold_page(input logic [MAX_Q-1:0] y0,
                                             input logic [MAX_Q-1:0] y1,
                                             input int q);
        fold_page_t       r;
        logic [MAX_Q-1:0] mask;
        logic [MAX_Q-1:0] y0f;
        logic [MAX_Q-1:0] y1f;
        mask   = MAX_Q'((1 << q) - 1);
        r.fold = |(y0 & (MAX_Q'(1) << (q - 1)));
        y0f    = (r.fold ? ~y0 : y0) & mask;
        y1f    = (r.fold ? ~y1 : y1) & mask;
        r.page = (MAX_PAGE_W'(y0f & (mask >> 1)) << q) | MAX_PAGE_W'(y1f);
        return r;
    endfunction

endpackage

// File: rtl/vnu_f1_multilane_if.sv
// LUT write bus shared by every replica: one write updates all replicas at once.
interface vnu_f1_multilane_if
    import vnu_f1_pkg::*;
#(
    parameter int QUAN_SIZE = 3,
    parameter int FRAME_W   = 1,
    parameter int PAGE_AW   = page_aw(QUAN_SIZE)
);
    logic                 we;
    logic [FRAME_W-1:0]   frame;
    logic [PAGE_AW-1:0]   page;
    logic [QUAN_SIZE-1:0] data;

    modport master (output we, frame, page, data);
    modport slave  (input  we, frame, page, data);
endinterface

// File: rtl/vnu_f1_lut_bank.sv
// One LUT replica: two synchronous read-first read ports sharing a frame index,
// one write port. Contents are never reset; only the read registers are.
module vnu_f1_lut_bank
    import vnu_f1_pkg::*;
#(
    parameter int QUAN_SIZE       = 3,
    parameter int MULTI_FRAME_NUM = 2,
    parameter int FRAME_W         = 1,
    parameter int PAGE_AW         = 5
) (
    input  logic                 read_clk,
    input  logic                 rstn,
    vnu_f1_multilane_if.slave    wr,
    input  logic [FRAME_W-1:0]   rd_frame,
    input  logic [PAGE_AW-1:0]   rd_page_a,
    input  logic [PAGE_AW-1:0]   rd_page_b,
    output logic [QUAN_SIZE-1:0] rd_data_a,
    output logic [QUAN_SIZE-1:0] rd_data_b
);
    localparam int DEPTH = MULTI_FRAME_NUM * (2 ** PAGE_AW);
    localparam int AW    = FRAME_W + PAGE_AW;

    logic [QUAN_SIZE-1:0] mem [DEPTH];
    logic [QUAN_SIZE-1:0] rd_a_d, rd_a_q, rd_b_d, rd_b_q;
    logic                 wr_ok, rd_ok;
    logic [AW-1:0]        wr_addr, rd_addr_a, rd_addr_b;

    // Frame indices past the last stored frame neither write nor read.
    always_comb begin
        wr_ok     = 32'(wr.frame) < 32'(MULTI_FRAME_NUM);
        rd_ok     = 32'(rd_frame) < 32'(MULTI_FRAME_NUM);
        wr_addr   = {wr.frame, wr.page};
        rd_addr_a = {rd_frame, rd_page_a};
        rd_addr_b = {rd_frame, rd_page_b};
        rd_a_d    = rd_ok ? mem[rd_addr_a] : '0;
        rd_b_d    = rd_ok ? mem[rd_addr_b] : '0;
    end

    always_ff @(posedge read_clk) begin
        if (wr.we && wr_ok) begin
            mem[wr_addr] <= wr.data;
        end
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign rd_data_a = rd_a_q;
    assign rd_data_b = rd_b_q;

endmodule

// File: rtl/vnu_f1_multilane.sv
// Multi-lane VNU.f1: fold + page address (stage 1), replicated LUT read with
// sign restore (stage 2), plus a free-running delay line for c2v_2.
module vnu_f1_multilane
    import vnu_f1_pkg::*;
#(
    parameter int  QUAN_SIZE       = 3,
    parameter int  LANES           = 4,
    parameter int  MULTI_FRAME_NUM = 2,
    parameter int  PIPELINE_DEPTH  = 2,
    localparam int FRAME_W         = frame_w(MULTI_FRAME_NUM),
    localparam int PAGE_AW         = page_aw(QUAN_SIZE)
) (
    input  logic                         read_clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    input  logic [FRAME_W-1:0]           read_addr_offset,
    input  logic [LANES*QUAN_SIZE-1:0]   t00,
    input  logic [LANES*QUAN_SIZE-1:0]   c2v_1,
    input  logic [LANES*QUAN_SIZE-1:0]   c2v_2,
    input  logic [LANES-1:0]             tranEn_in,
    input  logic                         ib_ram_we,
    input  logic [FRAME_W-1:0]           ram_write_frame,
    input  logic [PAGE_AW-1:0]           ram_write_page,
    input  logic [QUAN_SIZE-1:0]         ram_write_data,
    output logic [LANES*QUAN_SIZE-1:0]   v2c,
    output logic [LANES*QUAN_SIZE-1:0]   dn_in,
    output logic [LANES*QUAN_SIZE-1:0]   E_reg2,
    output logic [LANES-1:0]             tranEn_out,
    output logic                         out_valid,
    output logic [FRAME_W-1:0]           read_addr_offset_out
);
    localparam int LW = LANES * QUAN_SIZE;

    vnu_f1_multilane_if #(
        .QUAN_SIZE(QUAN_SIZE),
        .FRAME_W  (FRAME_W),
        .PAGE_AW  (PAGE_AW)
    ) wr_bus ();

    assign wr_bus.we    = ib_ram_we;
    assign wr_bus.frame = ram_write_frame;
    assign wr_bus.page  = ram_write_page;
    assign wr_bus.data  = ram_write_data;

    logic [LANES-1:0][PAGE_AW-1:0]   page_p1_d, page_p1_q;
    logic [LANES-1:0]                fold_p1_d, fold_p1_q, fold_p2_d, fold_p2_q;
    logic [LANES-1:0]                tran_p1_d, tran_p1_q, tran_p2_d, tran_p2_q;
    logic                            vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
    logic [FRAME_W-1:0]              frame_p1_d, frame_p1_q, frame_p2_d, frame_p2_q;
    logic [LANES-1:0][QUAN_SIZE-1:0] data_p2;
    logic [PIPELINE_DEPTH-1:0][LW-1:0] e_line_d, e_line_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fold_page_t fp;
        logic       unused_page_hi;
        assign fp = fold_page(MAX_Q'(t00[l*QUAN_SIZE +: QUAN_SIZE]),
                              MAX_Q'(c2v_1[l*QUAN_SIZE +: QUAN_SIZE]), QUAN_SIZE);
        assign fold_p1_d[l]    = fp.fold;
        assign page_p1_d[l]    = fp.page[PAGE_AW-1:0];
        assign unused_page_hi  = ^fp.page[MAX_PAGE_W-1:PAGE_AW];
        assign v2c[l*QUAN_SIZE +: QUAN_SIZE] = fold_p2_q[l] ? ~data_p2[l] : data_p2[l];
    end

    always_comb begin
        vld_p1_d    = in_valid;
        tran_p1_d   = tranEn_in;
        frame_p1_d  = read_addr_offset;
        vld_p2_d    = vld_p1_q;
        tran_p2_d   = tran_p1_q;
        frame_p2_d  = frame_p1_q;
        fold_p2_d   = fold_p1_q;
        e_line_d    = e_line_q;
        e_line_d[0] = c2v_2;
        for (int i = 1; i < PIPELINE_DEPTH; i++) begin
            e_line_d[i] = e_line_q[i-1];
        end
    end

    // Stage 1 -> stage 2 boundary; LUT data registers live in the banks.
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            page_p1_q  <= '0;
            fold_p1_q  <= '0;
            tran_p1_q  <= '0;
            vld_p1_q   <= 1'b0;
            frame_p1_q <= '0;
            fold_p2_q  <= '0;
            tran_p2_q  <= '0;
            vld_p2_q   <= 1'b0;
            frame_p2_q <= '0;
            e_line_q   <= '0;
        end else begin
            page_p1_q  <= page_p1_d;
            fold_p1_q  <= fold_p1_d;
            tran_p1_q  <= tran_p1_d;
            vld_p1_q   <= vld_p1_d;
            frame_p1_q <= frame_p1_d;
            fold_p2_q  <= fold_p2_d;
            tran_p2_q  <= tran_p2_d;
            vld_p2_q   <= vld_p2_d;
            frame_p2_q <= frame_p2_d;
            e_line_q   <= e_line_d;
        end
    end

    for (genvar k = 0; k < LANES / 2; k++) begin : g_bank
        vnu_f1_lut_bank #(
            .QUAN_SIZE      (QUAN_SIZE),
            .MULTI_FRAME_NUM(MULTI_FRAME_NUM),
            .FRAME_W        (FRAME_W),
            .PAGE_AW        (PAGE_AW)
        ) u_bank (
            .read_clk (read_clk),
            .rstn     (rstn),
            .wr       (wr_bus),
            .rd_frame (frame_p1_q),
            .rd_page_a(page_p1_q[2*k]),
            .rd_page_b(page_p1_q[2*k+1]),
            .rd_data_a(data_p2[2*k]),
            .rd_data_b(data_p2[2*k+1])
        );
    end

    assign dn_in                = data_p2;
    assign tranEn_out           = tran_p2_q;
    assign out_valid            = vld_p2_q;
    assign read_addr_offset_out = frame_p2_q;
    assign E_reg2               = e_line_q[PIPELINE_DEPTH-1];

endmodule

// File: tb/tb_vnu_f1_multilane.sv
// Scoreboard bench for vnu_f1_multilane: directed reads queue their expected
// outputs, a monitor compares them whenever out_valid is presented.
module tb_vnu_f1_multilane;

    localparam int Q   = 3;
    localparam int L   = 4;
    localparam int MFN = 3;
    localparam int PD  = 2;
    localparam int FW  = 2;
    localparam int PAW = 5;
    localparam int LW  = L * Q;

    logic          read_clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic [FW-1:0] read_addr_offset = '0;
    logic [LW-1:0] t00 = '0, c2v_1 = '0, c2v_2 = '0;
    logic [L-1:0]  tranEn_in = '0;
    logic [LW-1:0] v2c, dn_in, E_reg2;
    logic [L-1:0]  tranEn_out;
    logic          out_valid;
    logic [FW-1:0] read_addr_offset_out;

    vnu_f1_multilane_if #(.QUAN_SIZE(Q), .FRAME_W(FW), .PAGE_AW(PAW)) wr_bus ();

    vnu_f1_multilane #(
        .QUAN_SIZE(Q), .LANES(L), .MULTI_FRAME_NUM(MFN), .PIPELINE_DEPTH(PD)
    ) dut (
        .read_clk            (read_clk),
        .rstn                (rstn),
        .in_valid            (in_valid),
        .read_addr_offset    (read_addr_offset),
        .t00                 (t00),
        .c2v_1               (c2v_1),
        .c2v_2               (c2v_2),
        .tranEn_in           (tranEn_in),
        .ib_ram_we           (wr_bus.we),
        .ram_write_frame     (wr_bus.frame),
        .ram_write_page      (wr_bus.page),
        .ram_write_data      (wr_bus.data),
        .v2c                 (v2c),
        .dn_in               (dn_in),
        .E_reg2              (E_reg2),
        .tranEn_out          (tranEn_out),
        .out_valid           (out_valid),
        .read_addr_offset_out(read_addr_offset_out)
    );

    always #5 read_clk = ~read_clk;

    int cyc = 0;
    always @(posedge read_clk) cyc <= cyc + 1;

    typedef struct {
        logic [LW-1:0] dn;
        logic [LW-1:0] v2c;
        logic [LW-1:0] e;
        logic [L-1:0]  tr;
        logic [FW-1:0] fr;
        int            cyc;
    } exp_t;

    exp_t         sb[$];
    logic [Q-1:0] ref_mem [MFN][32];
    int           n_chk = 0;
    int           n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic vld, input logic [LW-1:0] t0, input logic [LW-1:0] c1,
                         input logic [LW-1:0] c2, input logic [L-1:0] tr, input logic [FW-1:0] fr,
                         input logic we, input logic [FW-1:0] wf, input logic [PAW-1:0] wp,
                         input logic [Q-1:0] wd);
        @(negedge read_clk);
        in_valid         = vld;
        t00              = t0;
        c2v_1            = c1;
        c2v_2            = c2;
        tranEn_in        = tr;
        read_addr_offset = fr;
        wr_bus.we        = we;
        wr_bus.frame     = wf;
        wr_bus.page      = wp;
        wr_bus.data      = wd;
        if (we && 32'(wf) < MFN) ref_mem[wf][wp] = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic wr(input logic [FW-1:0] f, input logic [PAW-1:0] p, input logic [Q-1:0] d);
        drive(1'b0, '0, '0, '0, '0, '0, 1'b1, f, p, d);
    endtask

    task automatic rdw(input logic [LW-1:0] t0, input logic [LW-1:0] c1, input logic [LW-1:0] c2,
                       input logic [L-1:0] tr, input logic [FW-1:0] fr,
                       input logic [LW-1:0] edn, input logic [LW-1:0] ev2c,
                       input logic we, input logic [FW-1:0] wf, input logic [PAW-1:0] wp,
                       input logic [Q-1:0] wd);
        exp_t e;
        drive(1'b1, t0, c1, c2, tr, fr, we, wf, wp, wd);
        e.dn = edn; e.v2c = ev2c; e.e = c2; e.tr = tr; e.fr = fr; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [LW-1:0] t0, input logic [LW-1:0] c1, input logic [LW-1:0] c2,
                      input logic [L-1:0] tr, input logic [FW-1:0] fr,
                      input logic [LW-1:0] edn, input logic [LW-1:0] ev2c);
        rdw(t0, c1, c2, tr, fr, edn, ev2c, 1'b0, '0, '0, '0);
    endtask

    // E_reg2 is compared with the c2v_2 of the issuing cycle since PD equals the read latency.
    initial begin
        exp_t e;
        forever begin
            @(negedge read_clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("dn_in",      32'(dn_in), 32'(e.dn));
                    chk("v2c",        32'(v2c), 32'(e.v2c));
                    chk("E_reg2",     32'(E_reg2), 32'(e.e));
                    chk("tranEn_out", 32'(tranEn_out), 32'(e.tr));
                    chk("offset_out", 32'(read_addr_offset_out), 32'(e.fr));
                    chk("latency",    32'(cyc - e.cyc), 32'd2);
                end
            end
        end
    end

    // Lane vectors are packed {lane3, lane2, lane1, lane0}.
    localparam logic [LW-1:0] T_A   = 12'b111_000_110_001;
    localparam logic [LW-1:0] C_A   = 12'b111_000_010_101;
    localparam logic [LW-1:0] DN_A  = 12'b001_001_101_101;
    localparam logic [LW-1:0] V2C_A = 12'b110_001_010_101;

    initial begin
        logic [LW-1:0]  t0, c1, edn;
        logic [PAW-1:0] pg;
        wr_bus.we = 1'b0; wr_bus.frame = '0; wr_bus.page = '0; wr_bus.data = '0;

        // Busy inputs while held in reset must not reach the outputs.
        @(negedge read_clk);
        in_valid = 1'b1; t00 = '1; c2v_1 = '1; c2v_2 = '1; tranEn_in = '1; read_addr_offset = 2'd2;
        repeat (3) @(negedge read_clk);
        chk("rst_out_valid",  {31'b0, out_valid}, 32'd0);
        chk("rst_dn_in",      32'(dn_in), 32'd0);
        chk("rst_v2c",        32'(v2c), 32'd0);
        chk("rst_E_reg2",     32'(E_reg2), 32'd0);
        chk("rst_tranEn_out", 32'(tranEn_out), 32'd0);
        chk("rst_offset_out", 32'(read_addr_offset_out), 32'd0);
        in_valid = 1'b0;
        rstn = 1'b1;

        for (int f = 0; f < MFN; f++)
            for (int p = 0; p < 32; p++)
                wr(2'(f), 5'(p), 3'((p * 3 + f * 5 + 1) & 7));

        // Lane0 plain and lane1 folded both land on frame0 page 0b01101.
        wr(2'd0, 5'd13, 3'b101);
        rd(T_A, C_A, 12'h0F0, 4'b1100, 2'd0, DN_A, V2C_A);
        idle(3);

        // Frame1 page5 holds 3'b101; the write lands in the LUT-read cycle of the first read.
        rd(12'b111_000_111_000, 12'b010_101_010_101, 12'h00A, 4'b0001, 2'd1,
           12'b101_101_101_101, 12'b010_101_010_101);
        rdw(12'b111_000_111_000, 12'b010_101_010_101, 12'h00B, 4'b0010, 2'd1,
            12'b111_111_111_111, 12'b000_111_000_111, 1'b1, 2'd1, 5'd5, 3'b111);
        idle(3);

        rd(T_A, C_A, 12'd1, 4'b1010, 2'd0, DN_A, V2C_A);
        rd(T_A, C_A, 12'd2, 4'b0101, 2'd0, DN_A, V2C_A);
        rd(T_A, C_A, 12'd3, 4'b1010, 2'd0, DN_A, V2C_A);
        rd('0, '0, 12'hABC, 4'b0110, 2'd2, 12'b011_011_011_011, 12'b011_011_011_011);
        idle(3);

        // Reset lands while the first read is on the outputs and the second is in flight.
        rd(T_A, C_A, 12'h111, 4'b1111, 2'd0, DN_A, V2C_A);
        rd(T_A, C_A, 12'h222, 4'b0011, 2'd0, DN_A, V2C_A);
        idle(1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_out_valid",  {31'b0, out_valid}, 32'd0);
        chk("async_rst_dn_in",      32'(dn_in), 32'd0);
        chk("async_rst_v2c",        32'(v2c), 32'd0);
        chk("async_rst_E_reg2",     32'(E_reg2), 32'd0);
        chk("async_rst_tranEn_out", 32'(tranEn_out), 32'd0);
        sb.delete();
        repeat (2) @(negedge read_clk);
        rstn = 1'b1;
        rd(T_A, C_A, 12'h5A5, 4'b1001, 2'd0, DN_A, V2C_A);
        idle(3);

        // Out-of-range frame: write ignored, full readback, then a read of frame 3.
        wr(2'd3, 5'd13, 3'b111);
        for (int f = 0; f < MFN; f++) begin
            for (int p = 0; p < 32; p += 4) begin
                t0 = '0; c1 = '0; edn = '0;
                for (int l = 0; l < L; l++) begin
                    pg = 5'(p + l);
                    t0[l*Q +: Q]  = {1'b0, pg[4:3]};
                    c1[l*Q +: Q]  = pg[2:0];
                    edn[l*Q +: Q] = ref_mem[f][pg];
                end
                rd(t0, c1, 12'(p), 4'(p), 2'(f), edn, edn);
            end
        end
        rd(12'b001_001_001_001, 12'b101_101_101_101, 12'h777, 4'b0100, 2'd3, '0, '0);
        idle(4);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
